// File: rtl/rob_tracked_queue.sv
// rob_tracked_queue: reorder-buffer core. Circular queue of DATA_W payloads with per-entry
// status (INVALID/PENDING/DONE/EXC), multi-lane allocate, multi-port completion,
// in-order multi-lane retire, head fault report, full flush and partial squash.
// Optional build macro ROB_PERF_CNT_EN adds retired-entry and stall performance counters.
module rob_tracked_queue #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ENQ_W     = 4,
  parameter int unsigned COMMIT_W  = 4,
  parameter int unsigned CMP_PORTS = 3,
  localparam int unsigned IDX_W    = $clog2(DEPTH),
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1),
  localparam int unsigned EW       = $clog2(ENQ_W + 1),
  localparam int unsigned CW       = $clog2(COMMIT_W + 1)
) (
  input  logic                          clk_in,
  input  logic                          rst_N_in,
  input  logic [EW-1:0]                 enq_cnt_in,
  input  logic [ENQ_W*DATA_W-1:0]       enq_data_in,
  output logic                          enq_ready_out,
  output logic [ENQ_W*IDX_W-1:0]        enq_idx_out,
  input  logic [CMP_PORTS-1:0]          cmp_valid_in,
  input  logic [CMP_PORTS*IDX_W-1:0]    cmp_idx_in,
  input  logic [CMP_PORTS-1:0]          cmp_exc_in,
  input  logic                          commit_ready_in,
  output logic [COMMIT_W-1:0]           commit_valid_out,
  output logic [COMMIT_W*DATA_W-1:0]    commit_data_out,
  output logic                          exc_valid_out,
  output logic [DATA_W-1:0]             exc_data_out,
  input  logic                          flush_in,
  input  logic                          squash_in,
  input  logic [IDX_W-1:0]              squash_idx_in,
  output logic [CNT_W-1:0]              count_out,
  output logic [CNT_W-1:0]              free_out,
  output logic                          empty_out,
  output logic                          full_out
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_commit_out,
  output logic [31:0]                   perf_stall_out
`endif
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_INVALID = 2'd0,
    ST_PENDING = 2'd1,
    ST_DONE    = 2'd2,
    ST_EXC     = 2'd3
  } status_e;

  status_e           status_q [DEPTH];
  status_e           status_d [DEPTH];
  logic [DATA_W-1:0] data_q   [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [IDX_W-1:0]  head_idx, tail_idx;
  logic [IDX_W-1:0]  sq_off;
  logic              squash_ok;
  logic              enq_ok;
  logic [CNT_W-1:0]  commit_lim;
  logic [CW-1:0]     n_done, n_ret;
  logic              run;
  logic [IDX_W-1:0]  cmp_idx [CMP_PORTS];
  logic [IDX_W-1:0]  cmp_off [CMP_PORTS];
  logic [CMP_PORTS-1:0] cmp_ok;
  logic [IDX_W-1:0]  ent_off;

  assign head_idx      = head_q[IDX_W-1:0];
  assign tail_idx      = tail_q[IDX_W-1:0];
  assign count_out     = CNT_W'(tail_q - head_q);
  assign free_out      = CNT_W'(DEPTH) - count_out;
  assign empty_out     = (count_out == '0);
  assign full_out      = (count_out == CNT_W'(DEPTH));
  assign enq_ready_out = (free_out >= CNT_W'(ENQ_W));
  assign exc_valid_out = !empty_out && (status_q[head_idx] == ST_EXC);
  assign exc_data_out  = data_q[head_idx];

  // Squash is honoured only when the surviving index lies inside [head, tail).
  assign sq_off    = squash_idx_in - head_idx;
  assign squash_ok = squash_in && (CNT_W'(sq_off) < count_out);

  // Whole-group allocate against pre-edge free slots; squash or flush drops it.
  assign enq_ok = (CNT_W'(enq_cnt_in) <= free_out) && !squash_ok && !flush_in;

  // Index handed to each allocate lane.
  always_comb begin
    enq_idx_out = '0;
    for (int i = 0; i < int'(ENQ_W); i++) begin
      enq_idx_out[i*IDX_W +: IDX_W] = tail_idx + IDX_W'(i);
    end
  end

  // Length of the DONE prefix from head, capped by lanes, live count and any squash point.
  always_comb begin
    commit_lim = count_out;
    if (squash_ok && (CNT_W'(sq_off) + CNT_W'(1) < count_out)) begin
      commit_lim = CNT_W'(sq_off) + CNT_W'(1);
    end
    n_done = '0;
    run    = 1'b1;
    for (int i = 0; i < int'(COMMIT_W); i++) begin
      if (run && (CNT_W'(i) < commit_lim) &&
          (status_q[head_idx + IDX_W'(i)] == ST_DONE)) begin
        n_done = n_done + CW'(1);
      end else begin
        run = 1'b0;
      end
    end
    n_ret = commit_ready_in ? n_done : '0;
  end

  // Retire lanes as a thermometer mask with the matching head payloads.
  always_comb begin
    commit_valid_out = '0;
    commit_data_out  = '0;
    for (int i = 0; i < int'(COMMIT_W); i++) begin
      commit_valid_out[i]                 = (CW'(i) < n_ret);
      commit_data_out[i*DATA_W +: DATA_W] = data_q[head_idx + IDX_W'(i)];
    end
  end

  // A completion lands only on a live PENDING entry.
  always_comb begin
    cmp_ok = '0;
    for (int p = 0; p < int'(CMP_PORTS); p++) begin
      cmp_idx[p] = cmp_idx_in[p*IDX_W +: IDX_W];
      cmp_off[p] = cmp_idx[p] - head_idx;
      cmp_ok[p]  = cmp_valid_in[p] && (CNT_W'(cmp_off[p]) < count_out) &&
                   (status_q[cmp_idx[p]] == ST_PENDING);
    end
  end

  // Next-state status: flush, else retire + completion (EXC wins), then squash or allocate.
  always_comb begin
    status_d = status_q;
    ent_off  = '0;
    if (flush_in) begin
      for (int j = 0; j < int'(DEPTH); j++) status_d[j] = ST_INVALID;
    end else begin
      for (int i = 0; i < int'(COMMIT_W); i++) begin
        if (CW'(i) < n_ret) status_d[head_idx + IDX_W'(i)] = ST_INVALID;
      end
      for (int p = 0; p < int'(CMP_PORTS); p++) begin
        if (cmp_ok[p]) begin
          if (cmp_exc_in[p]) status_d[cmp_idx[p]] = ST_EXC;
          else if (status_d[cmp_idx[p]] != ST_EXC) status_d[cmp_idx[p]] = ST_DONE;
        end
      end
      if (squash_ok) begin
        for (int j = 0; j < int'(DEPTH); j++) begin
          ent_off = IDX_W'(j) - head_idx;
          if ((CNT_W'(ent_off) < count_out) && (ent_off > sq_off)) status_d[j] = ST_INVALID;
        end
      end else if (enq_ok) begin
        for (int i = 0; i < int'(ENQ_W); i++) begin
          if (EW'(i) < enq_cnt_in) status_d[tail_idx + IDX_W'(i)] = ST_PENDING;
        end
      end
    end
  end

  // Status register.
  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      for (int j = 0; j < int'(DEPTH); j++) status_q[j] <= ST_INVALID;
    end else begin
      status_q <= status_d;
    end
  end

  // Head/tail pointers: reset > flush > squash > concurrent retire/allocate.
  always_ff @(posedge clk_in) begin
    if (!rst_N_in || flush_in) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_q + PTR_W'(n_ret);
      if (squash_ok) tail_q <= head_q + PTR_W'(sq_off) + PTR_W'(1);
      else if (enq_ok) tail_q <= tail_q + PTR_W'(enq_cnt_in);
    end
  end

  // Payload storage, written only for accepted allocate lanes.
  always_ff @(posedge clk_in) begin
    if (rst_N_in && enq_ok) begin
      for (int i = 0; i < int'(ENQ_W); i++) begin
        if (EW'(i) < enq_cnt_in) data_q[tail_idx + IDX_W'(i)] <= enq_data_in[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  // Retired-entry and stalled-head counters; wrap, clear on reset, hold on flush.
  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      perf_commit_out <= '0;
      perf_stall_out  <= '0;
    end else if (!flush_in) begin
      perf_commit_out <= perf_commit_out + 32'(n_ret);
      if (!empty_out && (n_done == '0)) perf_stall_out <= perf_stall_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_tracked_queue.sv
// tb_rob_tracked_queue: directed stimulus with a queue-based reference model and a per-cycle compare.
module tb_rob_tracked_queue;
  localparam int DEPTH = 64;
  localparam int DW    = 64;
  localparam int EQW   = 4;
  localparam int CMW   = 4;
  localparam int NP    = 3;
  localparam int IW    = 6;
  localparam int ST_PEND = 1;
  localparam int ST_DONE = 2;
  localparam int ST_EXC  = 3;

  logic            clk_in = 1'b0;
  logic            rst_N_in;
  logic [2:0]      enq_cnt_in;
  logic [EQW*DW-1:0] enq_data_in;
  logic            enq_ready_out;
  logic [EQW*IW-1:0] enq_idx_out;
  logic [NP-1:0]   cmp_valid_in;
  logic [NP*IW-1:0] cmp_idx_in;
  logic [NP-1:0]   cmp_exc_in;
  logic            commit_ready_in;
  logic [CMW-1:0]  commit_valid_out;
  logic [CMW*DW-1:0] commit_data_out;
  logic            exc_valid_out;
  logic [DW-1:0]   exc_data_out;
  logic            flush_in;
  logic            squash_in;
  logic [IW-1:0]   squash_idx_in;
  logic [6:0]      count_out;
  logic [6:0]      free_out;
  logic            empty_out;
  logic            full_out;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]     perf_commit_out;
  logic [31:0]     perf_stall_out;
`endif

  rob_tracked_queue dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in),
    .enq_cnt_in(enq_cnt_in), .enq_data_in(enq_data_in),
    .enq_ready_out(enq_ready_out), .enq_idx_out(enq_idx_out),
    .cmp_valid_in(cmp_valid_in), .cmp_idx_in(cmp_idx_in), .cmp_exc_in(cmp_exc_in),
    .commit_ready_in(commit_ready_in), .commit_valid_out(commit_valid_out),
    .commit_data_out(commit_data_out), .exc_valid_out(exc_valid_out),
    .exc_data_out(exc_data_out), .flush_in(flush_in), .squash_in(squash_in),
    .squash_idx_in(squash_idx_in), .count_out(count_out), .free_out(free_out),
    .empty_out(empty_out), .full_out(full_out)
`ifdef ROB_PERF_CNT_EN
    , .perf_commit_out(perf_commit_out), .perf_stall_out(perf_stall_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int retired = 0;

  typedef struct {
    logic [63:0] data;
    int          st;
  } ment_t;

  ment_t mq[$];
  int    mhead = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pay(input int s);
    return 64'hA5A5_0000_0000_0000 + 64'(s);
  endfunction

  // Length of the retiring DONE prefix the rules allow for the current model state and inputs.
  function automatic int model_commit_n();
    int sz, lim, off, n;
    sz  = mq.size();
    lim = (sz < CMW) ? sz : CMW;
    if (squash_in) begin
      off = (int'(squash_idx_in) - mhead + DEPTH) % DEPTH;
      if (off < sz && off + 1 < lim) lim = off + 1;
    end
    n = 0;
    while (n < lim && mq[n].st == ST_DONE) n++;
    if (!commit_ready_in) n = 0;
    return n;
  endfunction

  // Reference model: advances once per rising edge from the pre-edge inputs.
  int m_sz, m_n, m_off, m_sq_off;
  bit m_sq_ok;
  int upd[DEPTH];
  always @(posedge clk_in) begin
    if (!rst_N_in || flush_in) begin
      mq.delete();
      mhead = 0;
    end else begin
      m_sz     = mq.size();
      m_n      = model_commit_n();
      m_sq_off = (int'(squash_idx_in) - mhead + DEPTH) % DEPTH;
      m_sq_ok  = squash_in && (m_sq_off < m_sz);
      for (int k = 0; k < DEPTH; k++) upd[k] = 0;
      for (int p = 0; p < NP; p++) begin
        if (cmp_valid_in[p]) begin
          m_off = (int'(cmp_idx_in[p*IW +: IW]) - mhead + DEPTH) % DEPTH;
          if (m_off < m_sz && mq[m_off].st == ST_PEND) begin
            if (cmp_exc_in[p]) upd[m_off] = ST_EXC;
            else if (upd[m_off] != ST_EXC) upd[m_off] = ST_DONE;
          end
        end
      end
      for (int k = 0; k < m_sz; k++) if (upd[k] != 0) mq[k].st = upd[k];
      if (m_sq_ok) begin
        while (mq.size() > m_sq_off + 1) void'(mq.pop_back());
      end else if (int'(enq_cnt_in) <= DEPTH - m_sz) begin
        for (int i = 0; i < int'(enq_cnt_in); i++) begin
          ment_t e;
          e.data = enq_data_in[i*DW +: DW];
          e.st   = ST_PEND;
          mq.push_back(e);
        end
      end
      for (int i = 0; i < m_n; i++) void'(mq.pop_front());
      mhead = (mhead + m_n) % DEPTH;
    end
  end

  // Per-cycle compare of every output against the model.
  int c_sz, c_n;
  always @(negedge clk_in) begin
    if (chk_en) begin
      c_sz = mq.size();
      c_n  = model_commit_n();
      chk("count", 64'(count_out), 64'(c_sz));
      chk("free", 64'(free_out), 64'(DEPTH - c_sz));
      chk("empty", 64'(empty_out), 64'(c_sz == 0));
      chk("full", 64'(full_out), 64'(c_sz == DEPTH));
      chk("enq_ready", 64'(enq_ready_out), 64'(DEPTH - c_sz >= EQW));
      for (int i = 0; i < EQW; i++)
        chk("enq_idx", 64'(enq_idx_out[i*IW +: IW]), 64'((mhead + c_sz + i) % DEPTH));
      chk("commit_valid", 64'(commit_valid_out), 64'((1 << c_n) - 1));
      for (int i = 0; i < c_n; i++)
        chk("commit_data", commit_data_out[i*DW +: DW], mq[i].data);
      chk("exc_valid", 64'(exc_valid_out), 64'(c_sz > 0 && mq[0].st == ST_EXC));
      if (c_sz > 0 && mq[0].st == ST_EXC) chk("exc_data", exc_data_out, mq[0].data);
      retired += $countones(commit_valid_out);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
    enq_cnt_in   = '0;
    cmp_valid_in = '0;
    cmp_exc_in   = '0;
    flush_in     = 1'b0;
    squash_in    = 1'b0;
  endtask

  task automatic enq(input int n, input int base);
    enq_cnt_in = 3'(n);
    for (int i = 0; i < n; i++) enq_data_in[i*DW +: DW] = pay(base + i);
  endtask

  task automatic cmp(input int p, input int idx, input bit exc);
    cmp_valid_in[p]         = 1'b1;
    cmp_idx_in[p*IW +: IW]  = 6'(idx);
    cmp_exc_in[p]           = exc;
  endtask

  int enq_total, cmp_next, avail, cyc;

  initial begin
    rst_N_in = 1'b0; enq_cnt_in = '0; enq_data_in = '0; cmp_valid_in = '0;
    cmp_idx_in = '0; cmp_exc_in = '0; commit_ready_in = 1'b1; flush_in = 1'b0;
    squash_in = 1'b0; squash_idx_in = '0;

    // Reset held two cycles.
    @(posedge clk_in); #1; chk_en = 1'b1;
    tick();
    @(negedge clk_in);
    chk("t1_count", 64'(count_out), 64'd0);
    chk("t1_empty", 64'(empty_out), 64'd1);
    chk("t1_enq_ready", 64'(enq_ready_out), 64'd1);
    chk("t1_commit_valid", 64'(commit_valid_out), 64'd0);
    chk("t1_exc_valid", 64'(exc_valid_out), 64'd0);
    rst_N_in = 1'b1;
    tick();

    // Fill to DEPTH, then an overflowing group is dropped.
    for (int k = 0; k < 16; k++) begin enq(4, 4 * k); tick(); end
    @(negedge clk_in);
    chk("t2_count", 64'(count_out), 64'd64);
    chk("t2_full", 64'(full_out), 64'd1);
    chk("t2_enq_ready", 64'(enq_ready_out), 64'd0);
    enq(1, 999); tick();
    @(negedge clk_in);
    chk("t2_count_after_drop", 64'(count_out), 64'd64);

    // Out-of-order completion; head gates the retire.
    cmp(0, 1, 0); cmp(1, 2, 0); cmp(2, 3, 0); tick();
    @(negedge clk_in);
    chk("t3_no_commit", 64'(commit_valid_out), 64'd0);
    cmp(0, 0, 0); tick();
    @(negedge clk_in);
    chk("t3_commit_mask", 64'(commit_valid_out), 64'hF);
    chk("t3_lane0", commit_data_out[0 +: DW], pay(0));
    chk("t3_lane3", commit_data_out[3*DW +: DW], pay(3));
    tick();
    @(negedge clk_in);
    chk("t3_count", 64'(count_out), 64'd60);
    chk("t3_tail_wrap", 64'(enq_idx_out[0 +: IW]), 64'd0);

    // Faulting entry behind a done head, then flush.
    flush_in = 1'b1; tick();
    @(negedge clk_in);
    chk("t4_flush_count", 64'(count_out), 64'd0);
    enq(4, 100); tick();
    cmp(0, 1, 1); cmp(1, 0, 0); tick();
    @(negedge clk_in);
    chk("t4_commit_one", 64'(commit_valid_out), 64'h1);
    chk("t4_commit_data", commit_data_out[0 +: DW], pay(100));
    tick();
    @(negedge clk_in);
    chk("t4_exc_valid", 64'(exc_valid_out), 64'd1);
    chk("t4_exc_data", exc_data_out, pay(101));
    tick(); tick();
    @(negedge clk_in);
    chk("t4_held_count", 64'(count_out), 64'd3);
    flush_in = 1'b1; tick();
    @(negedge clk_in);
    chk("t4_flush2_count", 64'(count_out), 64'd0);
    chk("t4_exc_cleared", 64'(exc_valid_out), 64'd0);

    // Partial squash with a same-cycle enqueue that must be dropped.
    enq(4, 200); tick(); enq(4, 204); tick(); enq(2, 208); tick();
    squash_in = 1'b1; squash_idx_in = 6'd4; enq(2, 300); tick();
    @(negedge clk_in);
    chk("t5_count", 64'(count_out), 64'd5);
    chk("t5_tail", 64'(enq_idx_out[0 +: IW]), 64'd5);
    squash_in = 1'b1; squash_idx_in = 6'd20; tick();
    @(negedge clk_in);
    chk("t5_nonlive_squash", 64'(count_out), 64'd5);
    cmp(0, 7, 0); tick();
    enq(3, 400); tick();
    cmp(0, 0, 0); cmp(1, 1, 0); cmp(2, 2, 0); tick();
    cmp(0, 3, 0); cmp(1, 4, 0); cmp(2, 5, 0); tick();
    cmp(0, 6, 0); tick();
    repeat (4) tick();
    @(negedge clk_in);
    chk("t5_idx7_pending", 64'(count_out), 64'd1);
    chk("t5_no_commit", 64'(commit_valid_out), 64'd0);
    flush_in = 1'b1; tick();

    // Wrap-around stream with toggling commit_ready_in and stale completions.
    retired = 0; enq_total = 0; cmp_next = 0; cyc = 0;
    while (cyc < 600 && !(enq_total == 100 && mq.size() == 0)) begin
      avail = enq_total;
      if (enq_total < 100 && DEPTH - mq.size() >= 4) begin
        enq(4, 1000 + enq_total);
        enq_total += 4;
      end
      commit_ready_in = ((cyc % 3) != 2);
      for (int p = 0; p < NP; p++) begin
        if (p == 2 && (cyc % 5) == 4 && cmp_next >= 8) cmp(2, (cmp_next - 8) % DEPTH, 0);
        else if (cmp_next < avail) begin cmp(p, cmp_next % DEPTH, 0); cmp_next++; end
      end
      tick();
      cyc++;
    end
    commit_ready_in = 1'b1;
    @(negedge clk_in);
    chk("t6_drained", 64'(count_out), 64'd0);
    chk("t6_retired", 64'(retired), 64'd100);
    chk("t6_in_budget", 64'(cyc < 600), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
